ex_alu_unit: RTL and testbench

Execute-stage compute unit of the 16-bit pipelined processor. It combines three functions:
- ALU-control decode from ALUOp and the funct field.
- 16-bit ALU producing a result and a zero flag.
- Branch-offset shifter (immediate << 1) feeding the branch-target adder outside this block.
All outputs are registered on the single clock. Forwarding and ALUSrc operand muxes sit upstream; the operands arrive already selected.

---
 rtl/ex_alu_unit_if.sv | 28 ++
 rtl/ex_alu_unit.sv | 87 ++++++++
 tb/tb_ex_alu_unit.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/ex_alu_unit_if.sv
// Execute-stage ALU bus.
// Upstream drives the selected operands, the sign-extended immediate and
// ALUOp. The ALU returns the registered result, zero flag, decoded ALU
// control code and the shifted branch offset.
//   master : upstream pipeline side (drives operands, samples results)
//   slave  : ex_alu_unit side
interface ex_alu_unit_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic [WIDTH-1:0] adress;
  logic [1:0]       ALUOp;
  logic [WIDTH-1:0] adress_shifted;
  logic [2:0]       alu_control;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output data1, data2, adress, ALUOp,
    input  adress_shifted, alu_control, result, zero
  );

  modport slave (
    input  data1, data2, adress, ALUOp,
    output adress_shifted, alu_control, result, zero
  );
endinterface

// File: rtl/ex_alu_unit.sv
// Execute-stage compute unit: ALU-control decode, WIDTH-bit ALU with zero
// flag, and branch-offset shifter (immediate << 1). All outputs are
// registered with one-cycle latency; a new operation is accepted every cycle.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous active-high reset, clears every output
//   bus   : ex_alu_unit_if slave (data1, data2, adress, ALUOp in;
//           adress_shifted, alu_control, result, zero out)
module ex_alu_unit #(
  parameter int WIDTH = 16
) (
  input  logic         clock,
  input  logic         reset,
  ex_alu_unit_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOR = 3'b101,
    OP_SLT = 3'b110,
    OP_SLL = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic [WIDTH-1:0] shifted;
    logic [2:0]       ctrl;
    logic [WIDTH-1:0] res;
    logic             zero;
  } ex_rsp_t;

  logic [2:0]       ctrl;
  logic [WIDTH-1:0] res;
  ex_rsp_t          rsp_d;
  ex_rsp_t          rsp_q;

  // ALU-control decode; funct lives in the low immediate bits.
  always_comb begin
    ctrl = OP_ADD;
    unique case (bus.ALUOp)
      2'b00: ctrl = OP_ADD;
      2'b01: ctrl = OP_SUB;
      2'b10: ctrl = bus.adress[2:0];
      2'b11: ctrl = OP_OR;
      default: ctrl = OP_ADD;
    endcase
  end

  always_comb begin
    res = '0;
    unique case (alu_op_e'(ctrl))
      OP_ADD: res = bus.data1 + bus.data2;
      OP_SUB: res = bus.data1 - bus.data2;
      OP_AND: res = bus.data1 & bus.data2;
      OP_OR:  res = bus.data1 | bus.data2;
      OP_XOR: res = bus.data1 ^ bus.data2;
      OP_NOR: res = ~(bus.data1 | bus.data2);
      OP_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(bus.data1) < $signed(bus.data2))};
      // Only the low shift-amount bits count; upper data2 bits are ignored.
      OP_SLL: res = bus.data1 << bus.data2[SHW-1:0];
      default: res = '0;
    endcase
  end

  always_comb begin
    rsp_d         = '0;
    rsp_d.shifted = {bus.adress[WIDTH-2:0], 1'b0};
    rsp_d.ctrl    = ctrl;
    rsp_d.res     = res;
    rsp_d.zero    = (res == '0);
  end

  // zero is cleared on reset too, so it is 0 (not 1) during reset.
  always_ff @(posedge clock) begin
    if (reset) rsp_q <= '0;
    else       rsp_q <= rsp_d;
  end

  assign bus.adress_shifted = rsp_q.shifted;
  assign bus.alu_control    = rsp_q.ctrl;
  assign bus.result         = rsp_q.res;
  assign bus.zero           = rsp_q.zero;
endmodule

// File: tb/tb_ex_alu_unit.sv
module tb_ex_alu_unit;
  localparam int W = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  ex_alu_unit_if #(.WIDTH(W)) bus ();

  ex_alu_unit #(.WIDTH(W)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [15:0] res;
    logic        zero;
    logic [2:0]  ctrl;
    logic [15:0] shf;
  } exp_t;

  // Reference model written from the operation rules using integer math.
  function automatic exp_t model(input logic [1:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic [15:0] adr);
    exp_t e;
    int   sa, sb;
    int unsigned ua, ub, r;
    ua = a; ub = b;
    sa = (a >= 16'h8000) ? int'(a) - 65536 : int'(a);
    sb = (b >= 16'h8000) ? int'(b) - 65536 : int'(b);
    if (op == 2'd0) e.ctrl = 3'd0;
    else if (op == 2'd1) e.ctrl = 3'd1;
    else if (op == 2'd2) e.ctrl = adr[2:0];
    else e.ctrl = 3'd3;
    case (e.ctrl)
      3'd0: r = (ua + ub) % 65536;
      3'd1: r = (ua + 65536 - ub) % 65536;
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = 65535 - (ua | ub);
      3'd6: r = (sa < sb) ? 1 : 0;
      default: r = (ua * (2 ** (ub % 16))) % 65536;
    endcase
    e.res  = r[15:0];
    e.zero = (r == 0);
    r      = (int'(adr) * 2) % 65536;
    e.shf  = r[15:0];
    return e;
  endfunction

  task automatic apply(input logic [1:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] adr);
    bus.ALUOp = op; bus.data1 = a; bus.data2 = b; bus.adress = adr;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      apply(2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      checks++;
      if ({bus.result, bus.zero, bus.alu_control, bus.adress_shifted} !== 36'd0) begin
        errors++;
        $display("FAIL reset_outs res=%h zero=%b ctrl=%b shf=%h exp all 0",
                 bus.result, bus.zero, bus.alu_control, bus.adress_shifted);
      end
    end
    reset = 1'b0;
    apply(2'b00, 16'h0001, 16'h0001, 16'h0020);
    checks++;
    if (bus.result !== 16'h0002 || bus.zero !== 1'b0 || bus.alu_control !== 3'b000 ||
        bus.adress_shifted !== 16'h0040) begin
      errors++;
      $display("FAIL first_add res=%h zero=%b ctrl=%b shf=%h exp 0002 0 000 0040",
               bus.result, bus.zero, bus.alu_control, bus.adress_shifted);
    end
  endtask

  task automatic test_sub;
    apply(2'b01, 16'h1234, 16'h1234, 16'h0000);
    checks++;
    if (bus.result !== 16'h0000 || bus.zero !== 1'b1 || bus.alu_control !== 3'b001) begin
      errors++;
      $display("FAIL sub_equal res=%h zero=%b ctrl=%b exp 0000 1 001",
               bus.result, bus.zero, bus.alu_control);
    end
    apply(2'b01, 16'h0000, 16'h0001, 16'h0000);
    checks++;
    if (bus.result !== 16'hFFFF || bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL sub_wrap res=%h zero=%b exp ffff 0", bus.result, bus.zero);
    end
  endtask

  task automatic test_rtype_sweep;
    // 0xF0F0 << 3 truncates to 0x8780.
    logic [15:0] exp_res [8] = '{16'h00E3, 16'hE0FD, 16'h00F0, 16'hFFF3,
                                 16'hFF03, 16'h000C, 16'h0001, 16'h8780};
    for (int f = 0; f < 8; f++) begin
      apply(2'b10, 16'hF0F0, 16'h0FF3, 16'(f) | 16'h0AB8);
      checks++;
      if (bus.alu_control !== 3'(f) || bus.result !== exp_res[f] ||
          bus.zero !== (exp_res[f] == 16'd0)) begin
        errors++;
        $display("FAIL rtype_f%0d ctrl=%b res=%h zero=%b exp %b %h %b", f,
                 bus.alu_control, bus.result, bus.zero, 3'(f), exp_res[f],
                 (exp_res[f] == 16'd0));
      end
    end
  endtask

  task automatic test_boundaries;
    apply(2'b00, 16'hFFFF, 16'h0001, 16'h8001);
    checks++;
    if (bus.result !== 16'h0000 || bus.zero !== 1'b1) begin
      errors++;
      $display("FAIL add_wrap res=%h zero=%b exp 0000 1", bus.result, bus.zero);
    end
    checks++;
    if (bus.adress_shifted !== 16'h0002) begin
      errors++;
      $display("FAIL shift_msb shf=%h exp 0002", bus.adress_shifted);
    end
    apply(2'b10, 16'h8421, 16'h0011, 16'h0007);
    checks++;
    if (bus.result !== 16'h0842 || bus.alu_control !== 3'b111) begin
      errors++;
      $display("FAIL sll_mask res=%h ctrl=%b exp 0842 111", bus.result, bus.alu_control);
    end
  endtask

  task automatic test_slt;
    logic [15:0] a [3] = '{16'h8000, 16'h0001, 16'h5A5A};
    logic [15:0] b [3] = '{16'h0001, 16'h8000, 16'h5A5A};
    logic [15:0] r [3] = '{16'h0001, 16'h0000, 16'h0000};
    for (int i = 0; i < 3; i++) begin
      apply(2'b10, a[i], b[i], 16'h0006);
      checks++;
      if (bus.result !== r[i] || bus.zero !== (r[i] == 16'd0)) begin
        errors++;
        $display("FAIL slt_%0d res=%h zero=%b exp %h %b", i, bus.result, bus.zero,
                 r[i], (r[i] == 16'd0));
      end
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    apply(2'b00, 16'h1000, 16'h0234, 16'h0010);
    e = model(2'b00, 16'h1000, 16'h0234, 16'h0010);
    checks++;
    if (bus.result !== e.res || bus.adress_shifted !== e.shf) begin
      errors++;
      $display("FAIL b2b_pre res=%h shf=%h exp %h %h", bus.result, bus.adress_shifted,
               e.res, e.shf);
    end
    reset = 1'b1;
    apply(2'b10, 16'hFFFF, 16'h0001, 16'h7FF4);
    reset = 1'b0;
    checks++;
    if ({bus.result, bus.zero, bus.alu_control, bus.adress_shifted} !== 36'd0) begin
      errors++;
      $display("FAIL b2b_reset res=%h zero=%b ctrl=%b shf=%h exp all 0",
               bus.result, bus.zero, bus.alu_control, bus.adress_shifted);
    end
    apply(2'b11, 16'hA0A0, 16'h0505, 16'h0012);
    checks++;
    if (bus.alu_control !== 3'b011 || bus.result !== 16'hA5A5 || bus.zero !== 1'b0 ||
        bus.adress_shifted !== 16'h0024) begin
      errors++;
      $display("FAIL b2b_ori ctrl=%b res=%h zero=%b shf=%h exp 011 a5a5 0 0024",
               bus.alu_control, bus.result, bus.zero, bus.adress_shifted);
    end
  endtask

  task automatic test_random;
    exp_t e;
    logic [1:0]  op;
    logic [15:0] a, b, adr;
    for (int i = 0; i < 300; i++) begin
      op  = 2'($urandom);
      a   = 16'($urandom);
      b   = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
      adr = 16'($urandom);
      apply(op, a, b, adr);
      e = model(op, a, b, adr);
      checks++;
      if (bus.result !== e.res || bus.zero !== e.zero || bus.alu_control !== e.ctrl ||
          bus.adress_shifted !== e.shf) begin
        errors++;
        $display("FAIL rand_%0d op=%b a=%h b=%h adr=%h got %h %b %b %h exp %h %b %b %h",
                 i, op, a, b, adr, bus.result, bus.zero, bus.alu_control,
                 bus.adress_shifted, e.res, e.zero, e.ctrl, e.shf);
      end
    end
  endtask

  initial begin
    bus.ALUOp = 2'b00; bus.data1 = '0; bus.data2 = '0; bus.adress = '0;
    test_reset();
    test_sub();
    test_rtype_sweep();
    test_boundaries();
    test_slt();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
